// File: rtl/mdu_div_pkg.sv
// Shared CPU defines for the iterative divider: FSM states, widths and sign helpers.
package mdu_div_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned REM_W     = DATA_W + 1;
  localparam int unsigned DIV_STEPS = 32;
  localparam int unsigned CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Magnitude of v, treating it as two's complement only when is_signed is set.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v,
                                                input logic              is_signed);
    return (is_signed && v[DATA_W-1]) ? DATA_W'(~v + DATA_W'(1)) : v;
  endfunction

  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                 input logic              neg);
    return neg ? DATA_W'(~v + DATA_W'(1)) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division iteration on a 33-bit partial remainder.
module div_step
  import mdu_div_pkg::*;
(
  input  logic [REM_W-1:0]  rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] dvs_i,
  output logic [REM_W-1:0]  rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [REM_W-1:0] shifted;
  logic [REM_W-1:0] dvs_ext;
  logic             fits;

  // Bring the next dividend bit into the remainder, then try to subtract.
  always_comb begin
    shifted = {rem_i[REM_W-2:0], quo_i[DATA_W-1]};
    dvs_ext = {1'b0, dvs_i};
    fits    = (shifted >= dvs_ext);
    rem_o   = fits ? REM_W'(shifted - dvs_ext) : shifted;
    quo_o   = {quo_i[DATA_W-2:0], fits};
  end

endmodule

// File: rtl/mdu_div.sv
// Multi-cycle DIV/DIVU unit: 32 restoring steps, stalls the E stage while busy.
module mdu_div
  import mdu_div_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              div_en,
  input  logic              div_signed,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  input  logic              pipe_stall,
  input  logic              flush,
  output logic              div_stall,
  output logic              div_valid,
  output logic [DATA_W-1:0] quot,
  output logic [DATA_W-1:0] rem
);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REM_W-1:0]  prem_q, prem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic              sgn_q, sgn_d;
  logic [DATA_W-1:0] res_quot_q, res_quot_d;
  logic [DATA_W-1:0] res_rem_q, res_rem_d;
  logic              valid_q, valid_d;

  logic [REM_W-1:0]  step_rem;
  logic [DATA_W-1:0] step_quo;
  logic              opb_zero;

  assign opb_zero = (opb == '0);

  div_step u_div_step (
    .rem_i (prem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Hazard-unit stall: must drop in the same cycle as a flush.
  assign div_stall = ~flush & (((state_q == IDLE) & div_en & ~opb_zero) | (state_q == BUSY));
  assign div_valid = valid_q;
  assign quot      = res_quot_q;
  assign rem       = res_rem_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      prem_q     <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      sgn_q      <= 1'b0;
      res_quot_q <= '0;
      res_rem_q  <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prem_q     <= prem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      sgn_q      <= sgn_d;
      res_quot_q <= res_quot_d;
      res_rem_q  <= res_rem_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prem_d     = prem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    sgn_d      = sgn_q;
    res_quot_d = res_quot_q;
    res_rem_d  = res_rem_q;

    unique case (state_q)
      IDLE: begin
        if (div_en && !flush) begin
          if (opb_zero) begin
            res_quot_d = '1;
            res_rem_d  = opa;
            state_d    = DONE;
          end else begin
            // Operands are captured here only; later changes on opa/opb are ignored.
            quo_d   = abs_val(opa, div_signed);
            dvs_d   = abs_val(opb, div_signed);
            prem_d  = '0;
            cnt_d   = '0;
            sa_d    = opa[DATA_W-1];
            sb_d    = opb[DATA_W-1];
            sgn_d   = div_signed;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        prem_d = step_rem;
        quo_d  = step_quo;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIV_STEPS - 1)) begin
          res_quot_d = cond_neg(step_quo, sgn_q & (sa_q ^ sb_q));
          res_rem_d  = cond_neg(step_rem[DATA_W-1:0], sgn_q & sa_q);
          state_d    = DONE;
        end
      end
      DONE: begin
        if (!pipe_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) state_d = IDLE;
    valid_d = (state_d == DONE);
  end

endmodule

// File: doc/mdu_div.md
MDU_DIV -- requirements
Module: mdu_div

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have: resetn  input  1  synchronous reset, active-low.
REQ-003 SHALL have: div_en  input  1  E-stage instruction is DIV/DIVU and valid.
REQ-004 SHALL have: div_signed  input  1  1 = DIV (signed), 0 = DIVU.
REQ-005 SHALL have: opa  input  32  dividend (rs value, post-forwarding).
REQ-006 SHALL have: opb  input  32  divisor (rt value, post-forwarding).
REQ-007 SHALL have: pipe_stall  input  1  E stage held by another source (cache stall); the instruction does not advance.
REQ-008 SHALL have: flush  input  1  exception flush; the E-stage instruction is killed.
REQ-009 SHALL have: div_stall  output  1  drives alu_stallE of the hazard unit.
REQ-010 SHALL have: div_valid  output  1  result is ready.
REQ-011 SHALL have: quot  output  32  quotient, written to LO.
REQ-012 SHALL have: rem  output  32  remainder, written to HI.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 In IDLE with div_en=1, flush=0 and opb!=0: latch |opa|, |opb|, the sign bits and div_signed; clear the 5-bit iteration counter; go to BUSY.
REQ-015 In IDLE with div_en=1, flush=0 and opb==0: go to DONE; quot=32'hFFFF_FFFF, rem=opa.
REQ-016 In BUSY: perform one restoring radix-2 step per cycle with a 33-bit partial remainder; after 32 steps (counter 31) go to DONE.
REQ-017 In DONE with pipe_stall=0 (the instruction advances this cycle): go to IDLE. With pipe_stall=1: stay in DONE with results held.
REQ-018 div_stall SHALL be combinational: (IDLE & div_en & opb!=0) | BUSY, forced to 0 whenever flush=1.
REQ-019 Latency: with div_en seen in cycle 0, div_stall SHALL be high for cycles 0..32 and div_valid SHALL be high from cycle 33. Divide-by-zero: stall is high in no cycle and div_valid is high from cycle 1.
REQ-020 div_valid SHALL be 1 only in DONE. quot/rem SHALL be stable throughout DONE.
REQ-021 Signed sign fix: the quotient is negated if sign(opa)^sign(opb); the remainder takes the sign of opa.
REQ-022 Signed overflow: 32'h8000_0000 / 32'hFFFF_FFFF SHALL give quot=32'h8000_0000 and rem=0, with no special path required.
REQ-023 flush=1 in any state SHALL return the FSM to IDLE next cycle and discard any in-flight result.
REQ-024 div_en=0 while in BUSY (no flush) SHALL be ignored; the operation completes.
REQ-025 Operands SHALL be sampled only on the IDLE->BUSY/DONE transition; later operand changes SHALL have no effect.
REQ-026 Back-to-back divides: a new div_en in the cycle after DONE->IDLE SHALL start a fresh operation.

Reset
REQ-027 When resetn=0 at a clock edge: state=IDLE, counter=0, partial remainder/quotient regs=0, so div_stall=0, div_valid=0, quot=0, rem=0.
REQ-028 Reset asserted mid-BUSY SHALL abort the operation with no residual stall.

Structure
REQ-029 The state enum (IDLE/BUSY/DONE) and DIV_STEPS=32 SHALL reside in the shared CPU defines package.
REQ-030 One sub-module, div_step (combinational: one restoring iteration on the 33-bit remainder and 32-bit quotient), SHALL be instantiated once and iterated by mdu_div.

Verification
REQ-031 DIVU 100/7, pipe_stall=0 -> div_stall high 33 cycles; cycle 33: div_valid=1, quot=14, rem=2.
REQ-032 DIV -7/2 (32'hFFFF_FFF9, 2) -> quot=32'hFFFF_FFFD, rem=32'hFFFF_FFFF.
REQ-033 DIV 32'h8000_0000/32'hFFFF_FFFF -> quot=32'h8000_0000, rem=0. DIVU 5/0 -> div_stall never high, cycle 1: quot=32'hFFFF_FFFF, rem=5.
REQ-034 flush pulsed at cycle 10 of BUSY -> div_stall=0 in that cycle, IDLE next cycle, div_valid never asserted.
REQ-035 pipe_stall=1 for 4 cycles on entering DONE -> div_valid and results held 5 cycles, then IDLE. A second DIVU 9/3 immediately after -> quot=3, rem=0.
REQ-036 resetn=0 mid-BUSY -> next cycle div_stall=0, div_valid=0, quot=rem=0.
